// File: rtl/byte_rx_pkg.sv
// byte_rx_pkg: shared state encoding, default COM symbol and counter widths for the byte receiver.
package byte_rx_pkg;
   typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;
   localparam logic [7:0] COM_DEFAULT = 8'hBC;
   localparam int COM_CNT_W = 4;
   localparam int GAP_CNT_W = 8;
endpackage

// File: rtl/byte_rx_shifter.sv
// byte_rx_shifter: serial shift register presenting the candidate byte nxt and its COM compare.
module byte_rx_shifter
   import byte_rx_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL = COM_DEFAULT
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       serial_in,
   output logic [7:0] nxt,
   output logic       com_match
);
   // The oldest bit falls out of nxt on the next shift, so only seven are held.
   logic [6:0] sr;
   assign nxt = {sr, serial_in};
   assign com_match = nxt == COM_SYMBOL;
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) sr <= '0;
      else sr <= nxt[6:0];
endmodule

// File: rtl/byte_rx.sv
// byte_rx: serial-to-byte receiver that hunts for COM alignment, confirms lock and emits bytes.
// Define BYTE_RX_STRIP_COM_EN to drop COM bytes from the locked output stream.
module byte_rx
   import byte_rx_pkg::*;
#(
   parameter logic [7:0] COM_SYMBOL = COM_DEFAULT,
   parameter int         LOCK_COUNT = 4,
   parameter int         MAX_GAP    = 64
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       serial_in,
   output logic [7:0] DATA,
   output logic       Valid,
   output logic       aligned,
   output logic       lock_lost
);
   localparam logic [COM_CNT_W-1:0] LOCK_LAST = COM_CNT_W'(LOCK_COUNT - 1);
   localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(MAX_GAP - 1);
   state_t state;
   logic [2:0] bit_cnt;
   logic [COM_CNT_W-1:0] com_cnt;
   logic [GAP_CNT_W-1:0] gap_cnt;
   logic [7:0] nxt;
   logic com_match, boundary, drop, emit;
   byte_rx_shifter #(.COM_SYMBOL(COM_SYMBOL)) u_shifter (
      .CLK(CLK),
      .RESET(RESET),
      .serial_in(serial_in),
      .nxt(nxt),
      .com_match(com_match)
   );
   assign boundary = bit_cnt == 3'd7;
   assign drop = !com_match && gap_cnt == GAP_LAST;
`ifdef BYTE_RX_STRIP_COM_EN
   assign emit = !com_match && !drop;
`else
   assign emit = !drop;
`endif
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         state     <= SEARCH;
         bit_cnt   <= '0;
         com_cnt   <= '0;
         gap_cnt   <= '0;
         DATA      <= '0;
         Valid     <= 1'b0;
         aligned   <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         Valid     <= 1'b0;
         lock_lost <= 1'b0;
         bit_cnt   <= bit_cnt + 3'd1;
         case (state)
            SEARCH:
               if (com_match) begin
                  state   <= CHECK;
                  bit_cnt <= '0;
                  com_cnt <= COM_CNT_W'(1);
               end
            CHECK:
               if (boundary) begin
                  if (!com_match) begin
                     state   <= SEARCH;
                     com_cnt <= '0;
                  end else if (com_cnt == LOCK_LAST) begin
                     state   <= LOCKED;
                     gap_cnt <= '0;
                     aligned <= 1'b1;
                  end else com_cnt <= com_cnt + 1'b1;
               end
            LOCKED:
               if (boundary) begin
                  if (com_match) gap_cnt <= '0;
                  else if (drop) begin
                     state     <= SEARCH;
                     com_cnt   <= '0;
                     lock_lost <= 1'b1;
                     aligned   <= 1'b0;
                  end else gap_cnt <= gap_cnt + 1'b1;
                  if (emit) begin
                     DATA  <= nxt;
                     Valid <= 1'b1;
                  end
               end
            default: state <= SEARCH;
         endcase
      end
endmodule

// File: tb/tb_byte_rx.sv
// tb_byte_rx: randomized and directed checks of byte_rx against a stream-scanning reference model.
module tb_byte_rx;
   localparam int MAXG = 4;
   localparam int LOCKN = 4;
   localparam logic [7:0] COM = 8'hBC;
`ifdef BYTE_RX_STRIP_COM_EN
   localparam bit STRIP = 1'b1;
`else
   localparam bit STRIP = 1'b0;
`endif
   logic CLK = 1'b0, RESET = 1'b0, serial_in = 1'b0;
   logic [7:0] DATA;
   logic Valid, aligned, lock_lost;
   int total = 0, bad = 0, n = 0;
   bit bits[$];
   logic [7:0] got[$];
   logic o_v[2048], o_a[2048], o_l[2048], e_v[2048], e_a[2048], e_l[2048];
   logic [7:0] o_d[2048], e_d[2048];

   byte_rx #(.COM_SYMBOL(COM), .LOCK_COUNT(LOCKN), .MAX_GAP(MAXG)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .serial_in(serial_in),
      .DATA(DATA),
      .Valid(Valid),
      .aligned(aligned),
      .lock_lost(lock_lost)
   );

   always #5 CLK = ~CLK;

   task automatic add_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
   endtask

   task automatic add_junk(input int k);
      for (int i = 0; i < k; i++) bits.push_back(1'($urandom));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RESET = 1'b0;
      serial_in = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b1;
      bits.delete();
      got.delete();
   endtask

   // Bit i is sampled on edge i; outputs after edge i are observed at the following negedge.
   task automatic drive();
      n = bits.size();
      for (int i = 0; i < n; i++) begin
         serial_in = bits[i];
         @(posedge CLK);
         @(negedge CLK);
         o_v[i] = Valid;
         o_a[i] = aligned;
         o_l[i] = lock_lost;
         o_d[i] = DATA;
         if (Valid) got.push_back(DATA);
      end
   endtask

   function automatic logic [7:0] win(input int i);
      logic [7:0] v = '0;
      for (int k = i - 7; k <= i; k++) v = {v[6:0], (k >= 0) ? bits[k] : 1'b0};
      return v;
   endfunction

   // Scan the stream: hunt for COM, step byte-wise to confirm, then walk locked bytes.
   function automatic void model();
      int i, j, k, cnt, gap;
      logic [7:0] b, last;
      logic [7:0] e_b[2048];
      for (int t = 0; t < n; t++) begin
         e_v[t] = 0; e_a[t] = 0; e_l[t] = 0; e_b[t] = '0;
      end
      i = 0;
      while (i < n) begin
         while (i < n && win(i) != COM) i++;
         if (i >= n) break;
         cnt = 1;
         j = i;
         while (cnt < LOCKN) begin
            j += 8;
            if (j >= n || win(j) != COM) break;
            cnt++;
         end
         if (j >= n) break;
         if (cnt < LOCKN) begin
            i = j + 1;
            continue;
         end
         gap = 0;
         for (k = j + 8; k < n; k += 8) begin
            b = win(k);
            if (b == COM) gap = 0;
            else if (gap == MAXG - 1) break;
            else gap++;
            if (!(STRIP && b == COM)) begin
               e_v[k] = 1;
               e_b[k] = b;
            end
         end
         for (int t = j; t < n && t < k; t++) e_a[t] = 1;
         if (k >= n) break;
         e_l[k] = 1;
         i = k + 1;
      end
      last = '0;
      for (int t = 0; t < n; t++) begin
         if (e_v[t]) last = e_b[t];
         e_d[t] = last;
      end
   endfunction

   task automatic test_reset();
      RESET = 1'b0;
      @(negedge CLK);
      total++;
      if ({DATA, Valid, aligned, lock_lost} !== 11'd0) begin
         bad++;
         $display("FAIL reset got data=%h v=%b a=%b l=%b want all zero", DATA, Valid, aligned, lock_lost);
      end
      RESET = 1'b1;
   endtask

   task automatic test_clean_lock();
      do_reset();
      add_junk(3);
      repeat (4) add_byte(COM);
      add_byte(8'h5A);
      add_byte(8'hA5);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL clean t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (got.size() != 2 || got[0] !== 8'h5A || got[1] !== 8'hA5) begin
         bad++;
         $display("FAIL clean_bytes got %0d bytes want 5a,a5", got.size());
      end
      total++;
      if (o_a[33] !== 1'b0 || o_a[34] !== 1'b1) begin
         bad++;
         $display("FAIL clean_align got %b%b want 01", o_a[33], o_a[34]);
      end
   endtask

   task automatic test_offset_hunt();
      do_reset();
      add_junk(5);
      repeat (4) add_byte(COM);
      add_byte(8'h3C);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL hunt t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (got.size() != 1 || got[0] !== 8'h3C || o_a[36] !== 1'b1 || o_a[35] !== 1'b0) begin
         bad++;
         $display("FAIL hunt_bytes got %0d bytes align %b%b want 3c, 01", got.size(), o_a[35], o_a[36]);
      end
   endtask

   task automatic test_failed_check();
      do_reset();
      add_byte(COM);
      add_byte(COM);
      add_byte(8'h77);
      repeat (4) add_byte(COM);
      add_byte(8'h11);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL check t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (got.size() != 1 || got[0] !== 8'h11 || o_a[54] !== 1'b0 || o_a[55] !== 1'b1) begin
         bad++;
         $display("FAIL check_bytes got %0d bytes align %b%b want 11, 01", got.size(), o_a[54], o_a[55]);
      end
   endtask

   task automatic test_gap_loss();
      do_reset();
      repeat (4) add_byte(COM);
      for (int b = 0; b < 4; b++) add_byte(8'(b));
      repeat (4) add_byte(COM);
      add_byte(8'h44);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL gap t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (got.size() != 4 || got[0] !== 8'h00 || got[1] !== 8'h01 || got[2] !== 8'h02 || got[3] !== 8'h44) begin
         bad++;
         $display("FAIL gap_bytes got %0d bytes want 00,01,02,44", got.size());
      end
      total++;
      if ({o_l[62], o_l[63], o_a[62], o_a[63], o_a[95]} !== 5'b01101) begin
         bad++;
         $display("FAIL gap_loss got %b want 01101", {o_l[62], o_l[63], o_a[62], o_a[63], o_a[95]});
      end
   endtask

   task automatic test_reset_mid_byte();
      do_reset();
      repeat (4) add_byte(COM);
      add_byte(8'h5A);
      bits.push_back(0); bits.push_back(1); bits.push_back(1); bits.push_back(0);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL midrst_pre t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      RESET = 1'b0;
      #1;
      total++;
      if ({DATA, Valid, aligned} !== 10'd0 || o_d[n-1] !== 8'h5A || o_a[n-1] !== 1'b1) begin
         bad++;
         $display("FAIL midrst got data=%h v=%b a=%b (before data=%h a=%b) want 00/0/0 after 5a/1", DATA, Valid, aligned, o_d[n-1], o_a[n-1]);
      end
      @(negedge CLK);
      RESET = 1'b1;
      bits.delete();
      got.delete();
      bits.push_back(0); bits.push_back(1); bits.push_back(1); bits.push_back(0);
      add_byte(8'hAB);
      repeat (4) add_byte(COM);
      add_byte(8'h99);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL midrst_post t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (got.size() != 1 || got[0] !== 8'h99 || o_a[42] !== 1'b0 || o_a[43] !== 1'b1) begin
         bad++;
         $display("FAIL midrst_relock got %0d bytes align %b%b want 99, 01", got.size(), o_a[42], o_a[43]);
      end
   endtask

   task automatic test_strip();
      do_reset();
      repeat (4) add_byte(COM);
      add_byte(8'h22);
      add_byte(COM);
      add_byte(8'h33);
      drive();
      model();
      for (int t = 0; t < n; t++) begin
         total++;
         if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
            bad++;
            $display("FAIL strip t=%0d got %b%b%b/%h want %b%b%b/%h", t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
         end
      end
      total++;
      if (STRIP ? (got.size() != 2 || got[0] !== 8'h22 || got[1] !== 8'h33)
                : (got.size() != 3 || got[0] !== 8'h22 || got[1] !== COM || got[2] !== 8'h33)) begin
         bad++;
         $display("FAIL strip_bytes got %0d bytes want %0d", got.size(), STRIP ? 2 : 3);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         do_reset();
         add_junk($urandom_range(7));
         repeat (4) add_byte(COM);
         repeat (60) add_byte(($urandom_range(99) < 35) ? COM : 8'($urandom));
         drive();
         model();
         for (int t = 0; t < n; t++) begin
            total++;
            if ({o_v[t], o_a[t], o_l[t], o_d[t]} !== {e_v[t], e_a[t], e_l[t], e_d[t]}) begin
               bad++;
               $display("FAIL random r=%0d t=%0d got %b%b%b/%h want %b%b%b/%h", r, t, o_v[t], o_a[t], o_l[t], o_d[t], e_v[t], e_a[t], e_l[t], e_d[t]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_offset_hunt();
      test_failed_check();
      test_gap_loss();
      test_reset_mid_byte();
      test_strip();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
